// File: rtl/pipe_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : pipe_pkg                                                     |
// | Description : Shared opcode/ALUop constants and EX-stage control struct.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package pipe_pkg;

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_SW  = 6'h2b;

    localparam logic [3:0] ALU_AND  = 4'h0;
    localparam logic [3:0] ALU_OR   = 4'h1;
    localparam logic [3:0] ALU_XOR  = 4'h2;
    localparam logic [3:0] ALU_NOR  = 4'h3;
    localparam logic [3:0] ALU_SLL  = 4'h4;
    localparam logic [3:0] ALU_ADD  = 4'h5;
    localparam logic [3:0] ALU_SUB  = 4'h6;
    localparam logic [3:0] ALU_SRL  = 4'h7;
    localparam logic [3:0] ALU_SRA  = 4'h8;
    localparam logic [3:0] ALU_LUI  = 4'h9;
    localparam logic [3:0] ALU_SLTU = 4'ha;
    localparam logic [3:0] ALU_SLT  = 4'hb;

    // Control fields carried from ID through EX into EX/MEM.
    typedef struct packed {
        logic [3:0] aluop;
        logic       dmload;
        logic       dmstr;
        logic       dmsel;
        logic       regwr;
    } ex_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_if.sv
// +----------------------------------------------------------------------------+
// | Module      : id_ex_if                                                     |
// | Description : ID-side inputs and EX-side outputs of the ID/EX stage.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

interface id_ex_if #(
    parameter int DW   = 32,
    parameter int RW   = 5,
    parameter int CNTW = 32
);
    logic          id_valid;
    logic [3:0]    id_aluop;
    logic          id_dmload;
    logic          id_dmstr;
    logic          id_dmsel;
    logic [RW-1:0] id_ra;
    logic [RW-1:0] id_rb;
    logic [RW-1:0] id_rd;
    logic          id_regwr;
    logic [DW-1:0] id_a;
    logic [DW-1:0] id_b;
    logic [15:0]   id_imm;
    logic [DW-1:0] id_pc;
    logic          flush;

    logic          ex_valid;
    logic [3:0]    ex_aluop;
    logic          ex_dmload;
    logic          ex_dmstr;
    logic          ex_dmsel;
    logic [RW-1:0] ex_ra;
    logic [RW-1:0] ex_rb;
    logic [RW-1:0] ex_rd;
    logic          ex_regwr;
    logic [DW-1:0] ex_a;
    logic [DW-1:0] ex_b;
    logic [15:0]   ex_imm;
    logic [DW-1:0] ex_pc;
    logic          stall;
    logic [CNTW-1:0] stall_cnt;
    logic [CNTW-1:0] flush_cnt;

    modport master (
        output id_valid, id_aluop, id_dmload, id_dmstr, id_dmsel, id_ra, id_rb,
               id_rd, id_regwr, id_a, id_b, id_imm, id_pc, flush,
        input  ex_valid, ex_aluop, ex_dmload, ex_dmstr, ex_dmsel, ex_ra, ex_rb,
               ex_rd, ex_regwr, ex_a, ex_b, ex_imm, ex_pc, stall, stall_cnt,
               flush_cnt
    );

    modport slave (
        input  id_valid, id_aluop, id_dmload, id_dmstr, id_dmsel, id_ra, id_rb,
               id_rd, id_regwr, id_a, id_b, id_imm, id_pc, flush,
        output ex_valid, ex_aluop, ex_dmload, ex_dmstr, ex_dmsel, ex_ra, ex_rb,
               ex_rd, ex_regwr, ex_a, ex_b, ex_imm, ex_pc, stall, stall_cnt,
               flush_cnt
    );
endinterface

`default_nettype wire

// File: rtl/id_ex_stage_load_use_detect.sv
// +----------------------------------------------------------------------------+
// | Module      : load_use_detect                                              |
// | Description : Combinational load-use hazard check, ID sources vs EX load.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module load_use_detect #(
    parameter int RW = 5
) (
    input  wire logic          i_id_valid,
    input  wire logic [RW-1:0] i_id_ra,
    input  wire logic [RW-1:0] i_id_rb,
    input  wire logic          i_ex_valid,
    input  wire logic          i_ex_dmload,
    input  wire logic          i_ex_regwr,
    input  wire logic [RW-1:0] i_ex_rd,
    output logic               o_hazard
);
    logic w_ex_load;
    logic w_src_match;

    // rb is included: store data has no MEM-to-MEM forward path.
    assign w_ex_load   = i_ex_valid & i_ex_dmload & i_ex_regwr & (i_ex_rd != '0);
    assign w_src_match = (i_ex_rd == i_id_ra) | (i_ex_rd == i_id_rb);
    assign o_hazard    = i_id_valid & w_ex_load & w_src_match;
endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// +----------------------------------------------------------------------------+
// | Module      : id_ex_stage                                                  |
// | Description : ID/EX pipeline register with load-use stall and flush.       |
// |               STALL_CNT_EN enables the stall/flush statistics counters.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DW   = 32,
    parameter int RW   = 5,
    parameter int CNTW = 32
) (
    input  wire logic clk,
    input  wire logic rst_n,
    id_ex_if.slave    bus
);
    logic          r_valid;
    ex_ctrl_t      r_ctrl;
    logic [RW-1:0] r_ra;
    logic [RW-1:0] r_rb;
    logic [RW-1:0] r_rd;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [15:0]   r_imm;
    logic [DW-1:0] r_pc;

    ex_ctrl_t w_id_ctrl;
    logic     w_hazard;
    logic     w_stall;
    logic     w_bubble;

    assign w_id_ctrl = '{aluop:  bus.id_aluop,
                         dmload: bus.id_dmload,
                         dmstr:  bus.id_dmstr,
                         dmsel:  bus.id_dmsel,
                         regwr:  bus.id_regwr};

    load_use_detect #(.RW(RW)) u_detect (
        .i_id_valid  (bus.id_valid),
        .i_id_ra     (bus.id_ra),
        .i_id_rb     (bus.id_rb),
        .i_ex_valid  (r_valid),
        .i_ex_dmload (r_ctrl.dmload),
        .i_ex_regwr  (r_ctrl.regwr),
        .i_ex_rd     (r_rd),
        .o_hazard    (w_hazard)
    );

    // A flush discards the held instruction, so it never needs a stall.
    assign w_stall  = w_hazard & ~bus.flush;
    assign w_bubble = w_hazard | bus.flush;

    always_ff @(posedge clk) begin
        if (!rst_n || w_bubble) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_ra    <= '0;
            r_rb    <= '0;
            r_rd    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_imm   <= '0;
            r_pc    <= '0;
        end else begin
            r_valid <= bus.id_valid;
            r_ctrl  <= w_id_ctrl;
            r_ra    <= bus.id_ra;
            r_rb    <= bus.id_rb;
            r_rd    <= bus.id_rd;
            r_a     <= bus.id_a;
            r_b     <= bus.id_b;
            r_imm   <= bus.id_imm;
            r_pc    <= bus.id_pc;
        end
    end

`ifdef STALL_CNT_EN
    localparam logic [CNTW-1:0] c_cnt_one = {{(CNTW-1){1'b0}}, 1'b1};

    logic [CNTW-1:0] r_stall_cnt;
    logic [CNTW-1:0] r_flush_cnt;

    // Saturating counters: hold at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + c_cnt_one;
            if (bus.flush && bus.id_valid && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + c_cnt_one;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
`else
    assign bus.stall_cnt = '0;
    assign bus.flush_cnt = '0;
`endif

    assign bus.ex_valid  = r_valid;
    assign bus.ex_aluop  = r_ctrl.aluop;
    assign bus.ex_dmload = r_ctrl.dmload;
    assign bus.ex_dmstr  = r_ctrl.dmstr;
    assign bus.ex_dmsel  = r_ctrl.dmsel;
    assign bus.ex_regwr  = r_ctrl.regwr;
    assign bus.ex_ra     = r_ra;
    assign bus.ex_rb     = r_rb;
    assign bus.ex_rd     = r_rd;
    assign bus.ex_a      = r_a;
    assign bus.ex_b      = r_b;
    assign bus.ex_imm    = r_imm;
    assign bus.ex_pc     = r_pc;
    assign bus.stall     = w_stall;
endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_id_ex_stage                                               |
// | Description : Self-checking bench for id_ex_stage (CNTW = 2).              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_id_ex_stage;
    import pipe_pkg::*;

    localparam int DW   = 32;
    localparam int RW   = 5;
    localparam int CNTW = 2;
    localparam int c_cmax = (1 << CNTW) - 1;
`ifdef STALL_CNT_EN
    localparam int c_cnt_on = 1;
`else
    localparam int c_cnt_on = 0;
`endif

    typedef struct packed {
        logic        valid;
        logic [3:0]  aluop;
        logic        dmload;
        logic        dmstr;
        logic        dmsel;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  rd;
        logic        regwr;
        logic [31:0] a;
        logic [31:0] b;
        logic [15:0] imm;
        logic [31:0] pc;
    } stg_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush_in = 1'b0;
    stg_t id_in = '0;
    stg_t dut_ex;
    logic chk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    id_ex_if #(.DW(DW), .RW(RW), .CNTW(CNTW)) bus ();

    id_ex_stage #(.DW(DW), .RW(RW), .CNTW(CNTW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.id_valid  = id_in.valid;
    assign bus.id_aluop  = id_in.aluop;
    assign bus.id_dmload = id_in.dmload;
    assign bus.id_dmstr  = id_in.dmstr;
    assign bus.id_dmsel  = id_in.dmsel;
    assign bus.id_ra     = id_in.ra;
    assign bus.id_rb     = id_in.rb;
    assign bus.id_rd     = id_in.rd;
    assign bus.id_regwr  = id_in.regwr;
    assign bus.id_a      = id_in.a;
    assign bus.id_b      = id_in.b;
    assign bus.id_imm    = id_in.imm;
    assign bus.id_pc     = id_in.pc;
    assign bus.flush     = flush_in;

    assign dut_ex = '{valid: bus.ex_valid, aluop: bus.ex_aluop, dmload: bus.ex_dmload,
                      dmstr: bus.ex_dmstr, dmsel: bus.ex_dmsel, ra: bus.ex_ra,
                      rb: bus.ex_rb, rd: bus.ex_rd, regwr: bus.ex_regwr, a: bus.ex_a,
                      b: bus.ex_b, imm: bus.ex_imm, pc: bus.ex_pc};

    // Reference model: EX copy of last accepted instruction plus two counters.
    stg_t m_ex = '0;
    int   m_scnt = 0;
    int   m_fcnt = 0;
    logic m_hz;
    logic m_stall;

    always_comb begin
        m_hz = id_in.valid && m_ex.valid && m_ex.dmload && m_ex.regwr && (m_ex.rd != 5'd0)
               && ((m_ex.rd == id_in.ra) || (m_ex.rd == id_in.rb));
        m_stall = m_hz && !flush_in;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ex   <= '0;
            m_scnt <= 0;
            m_fcnt <= 0;
        end else begin
            m_ex <= (flush_in || m_hz) ? stg_t'('0) : id_in;
            if (m_stall && m_scnt < c_cmax) m_scnt <= m_scnt + 1;
            if (flush_in && id_in.valid && m_fcnt < c_cmax) m_fcnt <= m_fcnt + 1;
        end
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_ex", 256'(dut_ex), 256'(m_ex));
            chk("model_stall", 256'(bus.stall), 256'(m_stall));
            chk("model_stall_cnt", 256'(bus.stall_cnt), 256'(m_scnt * c_cnt_on));
            chk("model_flush_cnt", 256'(bus.flush_cnt), 256'(m_fcnt * c_cnt_on));
        end
    end

    function automatic stg_t mk(input logic v, input logic [3:0] op, input logic ld,
                                input logic st, input logic [4:0] ra, input logic [4:0] rb,
                                input logic [4:0] rd, input logic wr, input logic [31:0] pc);
        stg_t s;
        s = '{valid: v, aluop: op, dmload: ld, dmstr: st, dmsel: ld | st, ra: ra, rb: rb,
              rd: rd, regwr: wr, a: {pc[15:0], 16'h0a0a}, b: {16'hb0b0, pc[15:0]},
              imm: pc[15:0] ^ 16'h00f0, pc: pc};
        return s;
    endfunction

    // Apply one cycle of ID inputs; returns mid-cycle so outputs can be inspected.
    task automatic drive(input stg_t i, input logic f, input logic r);
        @(posedge clk);
        #1;
        id_in    = i;
        flush_in = f;
        rst_n    = r;
        @(negedge clk);
        #1;
    endtask

    stg_t add1, add2, add3, lw8, use8, lw0, use0, lw9, sw9, lw7, use7;

    initial begin
        add1 = mk(1, ALU_ADD, 0, 0, 5'd1, 5'd2, 5'd3, 1, 32'h100);
        add2 = mk(1, ALU_ADD, 0, 0, 5'd3, 5'd4, 5'd5, 1, 32'h104);
        add3 = mk(1, ALU_SUB, 0, 0, 5'd5, 5'd6, 5'd7, 1, 32'h108);
        lw8  = mk(1, ALU_ADD, 1, 0, 5'd29, 5'd0, 5'd8, 1, 32'h10c);
        use8 = mk(1, ALU_ADD, 0, 0, 5'd8, 5'd1, 5'd10, 1, 32'h110);
        lw0  = mk(1, ALU_ADD, 1, 0, 5'd29, 5'd0, 5'd0, 1, 32'h118);
        use0 = mk(1, ALU_ADD, 0, 0, 5'd0, 5'd0, 5'd11, 1, 32'h11c);
        lw9  = mk(1, ALU_ADD, 1, 0, 5'd29, 5'd0, 5'd9, 1, 32'h120);
        sw9  = mk(1, ALU_ADD, 0, 1, 5'd29, 5'd9, 5'd0, 0, 32'h124);
        lw7  = mk(1, ALU_ADD, 1, 0, 5'd29, 5'd0, 5'd7, 1, 32'h12c);
        use7 = mk(1, ALU_SLT, 0, 0, 5'd7, 5'd2, 5'd12, 1, 32'h130);

        // Reset
        drive('0, 1'b0, 1'b0);
        chk_en = 1'b1;
        drive('0, 1'b0, 1'b0);
        chk("reset_ex", 256'(dut_ex), 256'(0));
        chk("reset_stall", 256'(bus.stall), 256'(0));

        // Independent ADDs
        drive(add1, 1'b0, 1'b1);
        drive(add2, 1'b0, 1'b1);
        chk("add_ex_pc", 256'(bus.ex_pc), 256'(32'h100));
        drive(add3, 1'b0, 1'b1);
        chk("add_ex_rd", 256'(bus.ex_rd), 256'(5));
        chk("add_no_stall", 256'(bus.stall), 256'(0));

        // lw $8 ; add ra=$8
        drive(lw8, 1'b0, 1'b1);
        drive(use8, 1'b0, 1'b1);
        chk("lu_stall", 256'(bus.stall), 256'(1));
        drive(use8, 1'b0, 1'b1);
        chk("lu_bubble_valid", 256'(bus.ex_valid), 256'(0));
        chk("lu_bubble_aluop", 256'(bus.ex_aluop), 256'(0));
        chk("lu_stall_drop", 256'(bus.stall), 256'(0));
        chk("lu_stall_cnt", 256'(bus.stall_cnt), 256'(1 * c_cnt_on));
        drive(add1, 1'b0, 1'b1);
        chk("lu_add_in_ex", 256'(bus.ex_pc), 256'(32'h110));

        // lw $0 ; add ra=$0
        drive(lw0, 1'b0, 1'b1);
        drive(use0, 1'b0, 1'b1);
        chk("r0_no_stall", 256'(bus.stall), 256'(0));

        // lw $9 ; sw rb=$9
        drive(lw9, 1'b0, 1'b1);
        drive(sw9, 1'b0, 1'b1);
        chk("sw_stall", 256'(bus.stall), 256'(1));
        drive(sw9, 1'b0, 1'b1);
        drive(add1, 1'b0, 1'b1);
        chk("sw_in_ex", 256'(bus.ex_dmstr), 256'(1));
        chk("sw_stall_cnt", 256'(bus.stall_cnt), 256'(2 * c_cnt_on));

        // Hazard and flush together
        drive(lw7, 1'b0, 1'b1);
        drive(use7, 1'b1, 1'b1);
        chk("flush_no_stall", 256'(bus.stall), 256'(0));
        drive(use7, 1'b0, 1'b1);
        chk("flush_bubble", 256'(bus.ex_valid), 256'(0));
        chk("flush_cnt", 256'(bus.flush_cnt), 256'(1 * c_cnt_on));
        chk("flush_stall_cnt", 256'(bus.stall_cnt), 256'(2 * c_cnt_on));

        // Invalid ID instruction never stalls
        drive(lw8, 1'b0, 1'b1);
        use8.valid = 1'b0;
        drive(use8, 1'b0, 1'b1);
        chk("invalid_no_stall", 256'(bus.stall), 256'(0));
        use8.valid = 1'b1;
        drive(add1, 1'b0, 1'b1);
        chk("invalid_captured_ra", 256'(bus.ex_ra), 256'(8));

        // Reset during a stall cycle
        drive(lw8, 1'b0, 1'b1);
        drive(use8, 1'b0, 1'b0);
        drive(use8, 1'b0, 1'b1);
        chk("rst_mid_valid", 256'(bus.ex_valid), 256'(0));
        chk("rst_mid_stall", 256'(bus.stall), 256'(0));
        chk("rst_mid_cnt", 256'({bus.stall_cnt, bus.flush_cnt}), 256'(0));

        // Five load-use pairs saturate a 2-bit counter
        for (int k = 0; k < 5; k++) begin
            drive(lw8, 1'b0, 1'b1);
            drive(use8, 1'b0, 1'b1);
            drive(use8, 1'b0, 1'b1);
        end
        chk("sat_stall_cnt", 256'(bus.stall_cnt), 256'(3 * c_cnt_on));
        drive(add1, 1'b0, 1'b1);
        drive(add2, 1'b0, 1'b1);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the forwarding pipeline. It sits directly downstream of the instruction decoder and registers the decoded control fields (ALUop, dmload/dmstr/dmsel, ra/rb, imm), register-file read data and PC into the EX stage. It detects load-use hazards against the instruction currently in EX, asserts a one-cycle stall back to IF/ID and inserts a bubble. It also squashes on a redirect flush.

## Interface
- DW, 32, data/PC width
- RW, 5, register-address width
- CNTW, 32, statistics counter width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- id_valid  in  1  ID holds a real instruction
- id_aluop  in  4  decoded ALU operation
- id_dmload, id_dmstr, id_dmsel  in  1 each  decoded memory controls
- id_ra, id_rb  in  RW  source register addresses
- id_rd  in  RW  destination register
- id_regwr  in  1  instruction writes id_rd
- id_a, id_b  in  DW  register-file read data for ra/rb
- id_imm  in  16  immediate field
- id_pc  in  DW  instruction PC
- flush  in  1  redirect; squash the ID instruction
- ex_valid, ex_aluop, ex_dmload, ex_dmstr, ex_dmsel, ex_ra, ex_rb, ex_rd, ex_regwr, ex_a, ex_b, ex_imm, ex_pc  out  (widths as id_*)  registered EX-stage copy
- stall  out  1  hold PC and IF/ID this cycle
- stall_cnt  out  CNTW  load-use stalls taken
- flush_cnt  out  CNTW  valid instructions squashed by flush

## Operation
- hazard = id_valid & ex_valid & ex_dmload & ex_regwr & (ex_rd != 0) & (ex_rd == id_ra | ex_rd == id_rb). The hazard check covers store data (rb), because no MEM-to-MEM forwarding exists.
- stall = hazard & ~flush. The output is combinational from the EX registers and ID inputs.
- Each rising edge, with priority top-down:
  - rst_n = 0: all ex_* clear to 0 and both counters clear to 0.
  - flush = 1: a bubble is loaded.
  - hazard = 1: a bubble is loaded.
  - otherwise: all id_* are captured into ex_*.
- A bubble sets every ex_* to 0, including ex_valid, ex_regwr and all memory controls.
- A bubble in EX has ex_dmload = 0, so stall lasts exactly one cycle per load-use pair. On the next cycle the ID instruction, held by IF/ID, is captured normally.
- Register 0 never causes a hazard.
- An invalid ID instruction (id_valid = 0) is captured as-is. No stall is raised for it.

## Timing
- ID-to-EX latency is 1 cycle. No combinational path exists from id_* to ex_*.
- stall is valid in the same cycle as the offending ID instruction. The upstream block must hold IF/ID and PC while stall = 1.
- Simultaneous flush and hazard:
  - flush wins and stall = 0, because the held instruction is being discarded.
  - flush_cnt increments if id_valid = 1.
  - stall_cnt does not increment.
- stall_cnt increments on each cycle with stall = 1.
- Both counters saturate at 2^CNTW-1 and do not wrap.
- Reset mid-stall: the next cycle has ex_valid = 0 and stall = 0. No partial state survives.
- Reset values: every output is 0. stall is 0 because ex_valid = 0.

## Configuration
- STALL_CNT_EN defined: stall_cnt and flush_cnt count as specified above.
- STALL_CNT_EN undefined: no counter flops exist, and stall_cnt and flush_cnt are tied to 0.
- Pipeline behaviour is identical in both builds.

## Structure
- Shared package pipe_pkg holds:
  - opcode constants: OP_LW = 6'h23, OP_LBU = 6'h24, OP_SW = 6'h2b.
  - ALUop encodings: ALU_ADD = 4'h5, ALU_SUB = 4'h6, ALU_SLT = 4'hb, and the rest.
  - An ex_ctrl_t struct grouping the control fields. This struct is also used by the EX/MEM stage.
- One sub-module, load_use_detect, is natural. It is purely combinational, takes the ID and EX fields, and outputs hazard.
- id_ex_stage contains the registers, the flush/stall priority and the counters.

## Test plan
- Back-to-back independent ADDs: ex_* equal the id_* of the previous cycle, stall never rises, stall_cnt = 0.
- lw into $8, followed by add with ra = $8:
  - stall = 1 for one cycle, then EX holds a bubble (ex_valid = 0, ex_aluop = 0).
  - The add enters EX on the next cycle.
  - stall_cnt = 1.
- lw into $0, followed by add with ra = $0: no stall.
- lw into $9, followed by sw with rb = $9: one stall cycle, because the store-data dependency counts.
- Hazard present and flush = 1 in the same cycle: stall = 0, a bubble is loaded, flush_cnt = 1, stall_cnt unchanged.
- rst_n = 0 during a stall cycle, then released: all outputs 0. Counters saturate at 2^CNTW-1 when CNTW = 2 after 5 stalls (stall_cnt = 3).
